note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Score player that drives one note_synthesizer channel (octave/note/duty/effect).
//  Fetches 24-bit score words from a synchronous ROM, holds each note for a number of
//  tempo ticks, and supports rests, jumps (looping) and end-of-score.
//  Sits between the CPU control registers (start/stop/tempo) and the synthesizer.
// PARAMETERS
//  ADDR_W      8    score ROM address width
//  TEMPO_W     16   width of tempo divider input
//  MAX_JUMPS   2    consecutive JUMP words allowed before a note/rest; exceeding this is an error
// PORTS
//  baseclk     in   1        system clock, 25MHz
//  asyncrst    in   1        asynchronous reset, active-high
//  start       in   1        1-cycle pulse: play from address 0
//  stop        in   1        1-cycle pulse: abort playback
//  tempo_div   in   TEMPO_W  tick period = tempo_div+1 baseclk cycles; sampled at start
//  rom_rd      out  1        ROM read strobe
//  rom_addr    out  ADDR_W   ROM address
//  rom_data    in   24       ROM data, valid exactly 1 cycle after rom_rd
//  octave      out  3        to synthesizer
//  note        out  4        to synthesizer
//  duty        out  4        to synthesizer
//  effect      out  2        to synthesizer (00 = mute)
//  busy        out  1        high from start acceptance until return to IDLE
//  done        out  1        1-cycle pulse on END word or error
//  error       out  1        sticky; set on jump-limit violation, cleared by next accepted start
// BEHAVIOUR
//  Word format: [23:22] op (00 NOTE, 01 REST, 10 JUMP, 11 END), [21:20] effect,
//   [19:16] duty, [15:13] octave, [12:9] note, [7:0] length in ticks; JUMP target in [ADDR_W-1:0].
//  Reset: all outputs 0 (effect = mute, busy = 0, error = 0), state IDLE, PC = 0.
//  FSM states:
//   IDLE   -> FETCH on start; latches tempo_div; clears prescaler and error; PC = 0.
//   FETCH  -> rom_rd = 1, rom_addr = PC for one cycle -> WAIT.
//   WAIT   -> DECODE; rom_data is captured at the end of the WAIT cycle.
//   DECODE -> NOTE:  load octave/note/duty/effect, then PLAY.
//             REST:  effect = 00, others held, then PLAY.
//             JUMP:  PC = target, jump count +1, then FETCH.
//             END:   effect = 00, pulse done, then IDLE.
//   PLAY   -> counts ticks; after length ticks, PC = PC+1 (wraps at 2^ADDR_W) -> FETCH.
//  Output timing: outputs change on the clock edge leaving DECODE.
//   First note is visible 4 cycles after the start pulse.
//  Tick prescaler: counts 0..tempo_div; tick pulses on terminal count.
//   Runs only in PLAY. It is cleared on entry to PLAY, so each step lasts
//   exactly length*(tempo_div+1) cycles in PLAY.
//  Length: length = 0 is treated as 1. tempo_div = 0 gives a tick every cycle.
//  Jump limit: jump count is cleared by NOTE/REST. A JUMP arriving with
//   count == MAX_JUMPS sets error, mutes, pulses done and returns to IDLE.
//  Start/stop rules:
//   - stop in any non-IDLE state: effect = 00 next cycle, IDLE, no done pulse.
//   - start while busy is ignored.
//   - start and stop in the same cycle: stop wins, start is ignored.
//  Address wrap: PC increment past all-ones wraps to 0 (not an error).
//  asyncrst mid-playback: immediate return to reset values.
// STRUCTURE
//  Shared package note_seq_pkg: opcode constants, word field positions, FSM state
//   encodings, SCORE_W = 24.
//  Sub-module tempo_tick_gen (prescaler with clear/enable, tick output).
//   The FSM, PC, length counter and jump counter stay in note_sequencer.
// TESTING
//  1. ROM[0]=NOTE eff01 duty8 oct4 note9 len3, ROM[1]=END, tempo_div=9 -> first note visible
//     4 cycles after start; held 30 cycles in PLAY; then effect=00, done pulse; busy falls.
//  2. ROM[0]=REST len2, ROM[1]=NOTE len0 -> effect=00 for 2*(tempo_div+1) cycles;
//     len0 note lasts exactly 1 tick.
//  3. ROM[0]=NOTE len1, ROM[1]=JUMP 0 -> note replays indefinitely; busy stays 1;
//     stop mid-note -> effect=00 next cycle; no done pulse.
//  4. ROM[0]=JUMP 1, ROM[1]=JUMP 2, ROM[2]=JUMP 0 (MAX_JUMPS=2) -> error=1, done pulse,
//     IDLE; next start clears error.
//  5. start while busy -> ignored (PC is unchanged). start+stop in same cycle from IDLE ->
//     stays IDLE.
//  6. ADDR_W=2, ROM[3]=NOTE len1 -> PC wraps 3->0; asyncrst during PLAY -> all outputs 0
//     immediately.

Source files
------------

// File: rtl/note_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : note_seq_pkg
// Purpose  : Shared constants for the note sequencer: score word layout,
//            opcodes and FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package note_seq_pkg;

    localparam int SCORE_W = 24;

    // Opcodes, score word bits [23:22]
    localparam logic [1:0] c_op_note = 2'b00;
    localparam logic [1:0] c_op_rest = 2'b01;
    localparam logic [1:0] c_op_jump = 2'b10;
    localparam logic [1:0] c_op_end  = 2'b11;

    // Score word field positions
    localparam int c_op_hi   = 23;
    localparam int c_op_lo   = 22;
    localparam int c_eff_hi  = 21;
    localparam int c_eff_lo  = 20;
    localparam int c_duty_hi = 19;
    localparam int c_duty_lo = 16;
    localparam int c_oct_hi  = 15;
    localparam int c_oct_lo  = 13;
    localparam int c_note_hi = 12;
    localparam int c_note_lo = 9;
    localparam int c_len_hi  = 7;
    localparam int c_len_lo  = 0;

    localparam logic [1:0] c_eff_mute = 2'b00;

    // FSM state encodings
    localparam int         c_state_w    = 3;
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_fetch   = 3'd1;
    localparam logic [2:0] c_st_wait    = 3'd2;
    localparam logic [2:0] c_st_decode  = 3'd3;
    localparam logic [2:0] c_st_play    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/tempo_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tempo_tick_gen
// Purpose  : Tempo prescaler. Counts 0..i_tempo_div while enabled and pulses
//            o_tick on the terminal count, so ticks are i_tempo_div+1 cycles
//            apart. i_clear returns the count to 0 and has priority.
// Ports    : baseclk, asyncrst (async, active-high)
//            i_clear, i_enable, i_tempo_div[TEMPO_W-1:0] -> o_tick
// Revision : 1.0 - initial release
// ============================================================================
module tempo_tick_gen #(
    parameter int TEMPO_W = 16
) (
    input  logic               baseclk,
    input  logic               asyncrst,
    input  logic               i_clear,
    input  logic               i_enable,
    input  logic [TEMPO_W-1:0] i_tempo_div,
    output logic               o_tick
);

    logic [TEMPO_W-1:0] r_cnt;
    logic               w_term;

    assign w_term = (r_cnt == i_tempo_div);
    assign o_tick = i_enable && !i_clear && w_term;

    always_ff @(posedge baseclk or posedge asyncrst) begin
        if (asyncrst) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer
// Purpose  : Score player for one synthesizer channel. Fetches 24-bit score
//            words from a synchronous ROM and holds each note/rest for its
//            length in tempo ticks; supports jumps (with a limit on
//            back-to-back jumps) and end-of-score.
// Ports    : baseclk, asyncrst (async, active-high)
//            start, stop (pulses), tempo_div[TEMPO_W-1:0]
//            rom_rd, rom_addr[ADDR_W-1:0] -> ROM; rom_data[23:0] <- ROM
//            octave[2:0], note[3:0], duty[3:0], effect[1:0] -> synthesizer
//            busy, done (pulse), error (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int TEMPO_W   = 16,
    parameter int MAX_JUMPS = 2
) (
    input  logic               baseclk,
    input  logic               asyncrst,
    input  logic               start,
    input  logic               stop,
    input  logic [TEMPO_W-1:0] tempo_div,
    output logic               rom_rd,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [SCORE_W-1:0] rom_data,
    output logic [2:0]         octave,
    output logic [3:0]         note,
    output logic [3:0]         duty,
    output logic [1:0]         effect,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int c_jcnt_w = (MAX_JUMPS < 1) ? 1 : $clog2(MAX_JUMPS + 1);

    logic [c_state_w-1:0] r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [TEMPO_W-1:0]   r_tempo;
    logic [SCORE_W-1:0]   r_word;
    logic [7:0]           r_len;
    logic [c_jcnt_w-1:0]  r_jcnt;
    logic [2:0]           r_octave;
    logic [3:0]           r_note;
    logic [3:0]           r_duty;
    logic [1:0]           r_effect;
    logic                 r_done;
    logic                 r_error;

    logic [1:0]           w_op;
    logic [7:0]           w_len;
    logic                 w_tick;
    logic                 w_in_play;
    logic                 w_unused_bit8;

    assign w_op      = r_word[c_op_hi:c_op_lo];
    // A zero length plays for one tick
    assign w_len     = (r_word[c_len_hi:c_len_lo] == 8'd0) ? 8'd1 : r_word[c_len_hi:c_len_lo];
    assign w_in_play = (r_state == c_st_play);
    // Bit 8 of the score word is reserved
    assign w_unused_bit8 = r_word[8];

    // Prescaler is held clear outside PLAY so every step starts on a fresh tick period
    tempo_tick_gen #(
        .TEMPO_W (TEMPO_W)
    ) u_tick (
        .baseclk     (baseclk),
        .asyncrst    (asyncrst),
        .i_clear     (!w_in_play),
        .i_enable    (w_in_play),
        .i_tempo_div (r_tempo),
        .o_tick      (w_tick)
    );

    always_ff @(posedge baseclk or posedge asyncrst) begin
        if (asyncrst) begin
            r_state  <= c_st_idle;
            r_pc     <= '0;
            r_tempo  <= '0;
            r_word   <= '0;
            r_len    <= '0;
            r_jcnt   <= '0;
            r_octave <= '0;
            r_note   <= '0;
            r_duty   <= '0;
            r_effect <= c_eff_mute;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop && (r_state != c_st_idle)) begin
                // Abort: mute immediately, no done pulse
                r_state  <= c_st_idle;
                r_effect <= c_eff_mute;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        // stop in the same cycle suppresses start
                        if (start && !stop) begin
                            r_state <= c_st_fetch;
                            r_tempo <= tempo_div;
                            r_error <= 1'b0;
                            r_pc    <= '0;
                            r_jcnt  <= '0;
                        end
                    end
                    c_st_fetch: begin
                        r_state <= c_st_wait;
                    end
                    c_st_wait: begin
                        r_word  <= rom_data;
                        r_state <= c_st_decode;
                    end
                    c_st_decode: begin
                        case (w_op)
                            c_op_note: begin
                                r_octave <= r_word[c_oct_hi:c_oct_lo];
                                r_note   <= r_word[c_note_hi:c_note_lo];
                                r_duty   <= r_word[c_duty_hi:c_duty_lo];
                                r_effect <= r_word[c_eff_hi:c_eff_lo];
                                r_len    <= w_len;
                                r_jcnt   <= '0;
                                r_state  <= c_st_play;
                            end
                            c_op_rest: begin
                                r_effect <= c_eff_mute;
                                r_len    <= w_len;
                                r_jcnt   <= '0;
                                r_state  <= c_st_play;
                            end
                            c_op_jump: begin
                                if (r_jcnt == c_jcnt_w'(MAX_JUMPS)) begin
                                    r_error  <= 1'b1;
                                    r_effect <= c_eff_mute;
                                    r_done   <= 1'b1;
                                    r_state  <= c_st_idle;
                                end else begin
                                    r_pc    <= r_word[ADDR_W-1:0];
                                    r_jcnt  <= r_jcnt + 1'b1;
                                    r_state <= c_st_fetch;
                                end
                            end
                            default: begin
                                r_effect <= c_eff_mute;
                                r_done   <= 1'b1;
                                r_state  <= c_st_idle;
                            end
                        endcase
                    end
                    c_st_play: begin
                        if (w_tick) begin
                            if (r_len == 8'd1) begin
                                r_pc    <= r_pc + 1'b1;
                                r_state <= c_st_fetch;
                            end else begin
                                r_len <= r_len - 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign rom_rd   = (r_state == c_st_fetch);
    assign rom_addr = r_pc;
    assign octave   = r_octave;
    assign note     = r_note;
    assign duty     = r_duty;
    assign effect   = r_effect;
    assign busy     = (r_state != c_st_idle);
    assign done     = r_done;
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_sequencer
// Purpose  : Self-checking bench for note_sequencer with a behavioural
//            synchronous score ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;

    logic        baseclk = 1'b0;
    logic        asyncrst;
    logic        start;
    logic        stop;
    logic [15:0] tempo_div;
    logic        rom_rd;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data = 24'd0;
    logic [2:0]  octave;
    logic [3:0]  note;
    logic [3:0]  duty;
    logic [1:0]  effect;
    logic        busy;
    logic        done;
    logic        error;

    logic [23:0] rom [0:255];
    int          total = 0;
    int          bad   = 0;

    localparam logic [23:0] W_END = 24'hC00000;

    note_sequencer #(
        .ADDR_W    (8),
        .TEMPO_W   (16),
        .MAX_JUMPS (2)
    ) u_dut (
        .baseclk   (baseclk),
        .asyncrst  (asyncrst),
        .start     (start),
        .stop      (stop),
        .tempo_div (tempo_div),
        .rom_rd    (rom_rd),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .octave    (octave),
        .note      (note),
        .duty      (duty),
        .effect    (effect),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 baseclk = ~baseclk;

    always @(posedge baseclk) begin
        if (rom_rd) rom_data <= rom[rom_addr];
    end

    typedef struct {
        logic [15:0] div;
        logic [7:0]  len;
        logic [1:0]  eff;
        logic [3:0]  duty;
        logic [2:0]  oct;
        logic [3:0]  nt;
        int          hold;   // cycles effect stays on: len*(div+1) + 3
    } vec_t;

    vec_t vecs [4];

    function automatic logic [23:0] mk_note(input logic [1:0] eff, input logic [3:0] d,
                                            input logic [2:0] o, input logic [3:0] n,
                                            input logic [7:0] len);
        return {2'b00, eff, d, o, n, 1'b0, len};
    endfunction

    function automatic logic [23:0] mk_rest(input logic [7:0] len);
        return {2'b01, 14'd0, len};
    endfunction

    function automatic logic [23:0] mk_jump(input logic [7:0] tgt);
        return {2'b10, 14'd0, tgt};
    endfunction

    task automatic tick();
        @(posedge baseclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = W_END;
    endtask

    // Count cycles while effect holds the given value (bounded)
    task automatic hold_cycles(input logic [1:0] eff, output int n);
        n = 0;
        while (effect === eff && n < 5000) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int  n;
        bit  saw_done;

        asyncrst  = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        tempo_div = 16'd0;
        clear_rom();
        #1;
        check("reset_outputs", {7'd0, rom_rd, rom_addr, octave, note, duty, effect, busy, done, error}, 32'd0);
        tick();
        tick();
        asyncrst = 1'b0;
        tick();

        // ---------------- table-driven NOTE + END runs ----------------
        vecs[0] = '{div: 16'd9, len: 8'd3, eff: 2'b01, duty: 4'd8,  oct: 3'd4, nt: 4'd9,  hold: 33};
        vecs[1] = '{div: 16'd3, len: 8'd0, eff: 2'b10, duty: 4'd15, oct: 3'd7, nt: 4'd0,  hold: 7};
        vecs[2] = '{div: 16'd0, len: 8'd5, eff: 2'b11, duty: 4'd1,  oct: 3'd0, nt: 4'd15, hold: 8};
        vecs[3] = '{div: 16'd1, len: 8'd2, eff: 2'b01, duty: 4'd6,  oct: 3'd3, nt: 4'd11, hold: 7};

        for (int i = 0; i < 4; i++) begin
            clear_rom();
            rom[0] = mk_note(vecs[i].eff, vecs[i].duty, vecs[i].oct, vecs[i].nt, vecs[i].len);
            rom[1] = W_END;
            tempo_div = vecs[i].div;
            pulse_start();                 // now cycle 1
            check("busy_after_start", {31'd0, busy}, 32'd1);
            tick();
            tick();                        // cycle 3
            check("pre_note_mute", {30'd0, effect}, 32'd0);
            tick();                        // cycle 4: note visible
            check("note_fields", {19'd0, octave, note, duty, effect},
                  {19'd0, vecs[i].oct, vecs[i].nt, vecs[i].duty, vecs[i].eff});
            hold_cycles(vecs[i].eff, n);
            check("note_hold", n, vecs[i].hold);
            check("end_done_busy_eff", {28'd0, done, busy, effect}, {28'd0, 4'b1000});
            tick();
            check("done_one_cycle", {31'd0, done}, 32'd0);
        end

        // ---------------- REST then zero-length NOTE ----------------
        clear_rom();
        rom[0] = mk_rest(8'd2);
        rom[1] = mk_note(2'b10, 4'd3, 3'd2, 4'd5, 8'd0);
        rom[2] = W_END;
        tempo_div = 16'd4;
        pulse_start();
        tick(); tick(); tick();            // cycle 4
        check("rest_mute_busy", {29'd0, busy, effect}, {29'd0, 3'b100});
        hold_cycles(2'b00, n);
        check("rest_len", n, 13);          // 2*5 + 3
        check("len0_fields", {19'd0, octave, note, duty, effect}, {19'd0, 3'd2, 4'd5, 4'd3, 2'b10});
        hold_cycles(2'b10, n);
        check("len0_hold", n, 8);          // 1*5 + 3
        check("rest_seq_done", {31'd0, done}, 32'd1);
        tick();

        // ---------------- endless loop, then stop ----------------
        clear_rom();
        rom[0] = mk_note(2'b11, 4'd1, 3'd1, 4'd1, 8'd1);
        rom[1] = mk_jump(8'd0);
        tempo_div = 16'd2;
        pulse_start();
        tick(); tick(); tick();
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("loop_busy_eff", {29'd0, busy, effect}, {29'd0, 3'b111});
        check("loop_no_done", {31'd0, saw_done}, 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_mute", {28'd0, effect, busy, done}, 32'd0);
        tick();
        check("stop_no_done", {30'd0, done, busy}, 32'd0);

        // ---------------- jump limit ----------------
        clear_rom();
        rom[0] = mk_jump(8'd1);
        rom[1] = mk_jump(8'd2);
        rom[2] = mk_jump(8'd0);
        tempo_div = 16'd0;
        pulse_start();                     // cycle 1
        repeat (8) tick();                 // cycle 9: decoding third JUMP
        check("jump_pre_err", {30'd0, busy, error}, {30'd0, 2'b10});
        tick();                            // cycle 10
        check("jump_err", {27'd0, error, done, busy, effect}, {27'd0, 5'b11000});
        tick();
        check("err_sticky", {30'd0, error, done}, {30'd0, 2'b10});
        clear_rom();
        rom[0] = mk_note(2'b01, 4'd2, 3'd2, 4'd2, 8'd1);
        rom[1] = W_END;
        pulse_start();
        check("err_cleared", {31'd0, error}, 32'd0);
        tick(); tick(); tick();
        hold_cycles(2'b01, n);
        check("after_err_hold", n, 4);
        tick();

        // ---------------- start while busy; start+stop in IDLE ----------------
        clear_rom();
        rom[0] = mk_note(2'b01, 4'd4, 3'd6, 4'd3, 8'd4);
        rom[1] = W_END;
        tempo_div = 16'd3;
        pulse_start();
        tick(); tick(); tick();            // cycle 4
        tick(); tick();                    // cycle 6, in PLAY
        pulse_start();                     // cycle 7, should be ignored
        hold_cycles(2'b01, n);
        check("busy_start_ignored", n, 16);
        check("busy_start_done", {31'd0, done}, 32'd1);
        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle", {30'd0, busy, rom_rd}, 32'd0);
        tick();
        check("start_stop_idle2", {30'd0, busy, rom_rd}, 32'd0);

        // ---------------- PC wrap and async reset ----------------
        clear_rom();
        rom[0]   = mk_jump(8'hFF);
        rom[255] = mk_note(2'b01, 4'd2, 3'd5, 4'd7, 8'd1);
        tempo_div = 16'd0;
        pulse_start();                     // cycle 1
        tick(); tick(); tick();            // cycle 4: fetch of jump target
        check("jump_fetch", {23'd0, rom_rd, rom_addr}, {23'd0, 1'b1, 8'hFF});
        tick(); tick(); tick();            // cycle 7
        check("wrap_note", {19'd0, octave, note, duty, effect}, {19'd0, 3'd5, 4'd7, 4'd2, 2'b01});
        tick();                            // cycle 8
        check("pc_wrap", {23'd0, rom_rd, rom_addr}, {23'd0, 1'b1, 8'h00});
        repeat (6) tick();                 // cycle 14, in PLAY
        check("pre_rst_play", {29'd0, busy, effect}, {29'd0, 3'b101});
        asyncrst = 1'b1;
        #1;
        check("async_rst", {7'd0, rom_rd, rom_addr, octave, note, duty, effect, busy, done, error}, 32'd0);
        tick();
        asyncrst = 1'b0;
        tick();
        check("post_rst_idle", {29'd0, busy, effect}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
